arm_mc_controller: RTL and testbench

- Multicycle ARM control unit: main FSM plus instruction-field decoders.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects, IRWrite and NextPC directly.
- Produces the unconditioned write requests (PCS, RegW, MemW, FlagW) that the condition-check stage gates with the condition-code result. This block is the producing end of that interface.

---
 rtl/arm_mc_controller.sv | 191 +++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
// ---------------------------------------------------------------------------
// arm_mc_controller
//
// Multicycle ARM control unit. A Moore main FSM steps each instruction through
// fetch / decode / execute / memory / writeback. Instruction-field decoders
// produce the ALU operation, the immediate/register-source selects, and the
// unconditioned write requests (PCS, RegW, MemW, FlagW). These requests are
// consumed by the downstream condition-check stage, which gates them with the
// condition-code result.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; forces FETCH
//   Op          instr[27:26]
//   Funct       instr[25:20]
//   Rd          instr[15:12]
//   State       current FSM state (debug / verification)
//   IRWrite     instruction register load enable
//   NextPC      unconditional PC write (fetch increment)
//   AdrSrc      memory address: 0 = PC, 1 = ALU result
//   ALUSrcA     0 = register A, 1 = PC
//   ALUSrcB     00 = register B, 01 = ext. immediate, 10 = constant 4
//   ResultSrc   00 = ALUOut, 01 = read data, 10 = ALU result
//   ALUControl  00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc      equal to Op
//   RegSrc      [0] = (Op==10), [1] = (Op==01)
//   FlagW       [1] = NZ write request, [0] = CV write request
//   PCS         PC-source write request
//   RegW        register write request
//   MemW        memory write request
// ---------------------------------------------------------------------------
module arm_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [3:0] State,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    UNKNOWN = 4'd10
  } state_t;

  state_t state_q, state_d;
  logic   nowrite_q, nowrite_d;

  logic   alu_op;
  logic   branch;
  logic   alu_nowrite;

  // State register and the NoWrite flag captured during execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nowrite_q <= nowrite_d;
    end
  end

  // Next-state logic; unreachable encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // NoWrite is sampled while the ALU decode is live and held through ALUWB,
  // where the register write request depends on it.
  always_comb begin
    nowrite_d = nowrite_q;
    if (state_q == EXECR || state_q == EXECI) nowrite_d = alu_nowrite;
  end

  // Per-state Moore outputs
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: RegW = ~nowrite_q;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode from Funct[4:1]; S bit (Funct[0]) requests the flag writes.
  // Unrecognised opcodes produce ADD with no flag write.
  always_comb begin
    ALUControl  = 2'b00;
    FlagW       = 2'b00;
    alu_nowrite = 1'b0;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; FlagW = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; FlagW = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; FlagW = {Funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; FlagW = {Funct[0], 1'b0};     end
        4'b1010: begin
          ALUControl  = 2'b01;
          FlagW       = {Funct[0], Funct[0]};
          alu_nowrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCS    = branch | (RegW & (Rd == 4'd15));
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
  assign State  = state_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] State;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
  logic       PCS, RegW, MemW;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .State(State), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW)
  );

  always #5 clk = ~clk;

  // Packed view of every output, in the same field order as mk()
  logic [22:0] act;
  assign act = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUControl, ImmSrc, RegSrc, FlagW, PCS, RegW, MemW};

  typedef struct {
    string       name;
    logic [22:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [22:0] mk(
    input logic [3:0] st, input logic irw, input logic npc, input logic adr,
    input logic sa, input logic [1:0] sb, input logic [1:0] rs,
    input logic [1:0] alu, input logic [1:0] imm, input logic [1:0] rsrc,
    input logic [1:0] fw, input logic pcs, input logic rw, input logic mw);
    return {st, irw, npc, adr, sa, sb, rs, alu, imm, rsrc, fw, pcs, rw, mw};
  endfunction

  // Monitor: one output vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                 e.name, act, act[22:19], e.vec, e.vec[22:19]);
      end
    end
  end

  // Called at posedge+1: queue the expected vector for this cycle, advance
  task automatic cyc(input string name, input logic [22:0] v);
    exp_t e;
    e.name = name;
    e.vec  = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd);
    Op = op; Funct = f; Rd = rd;
  endtask

  // FETCH / DECODE vectors depend only on Op through ImmSrc/RegSrc
  function automatic logic [22:0] fetch_v(input logic [1:0] imm,
                                          input logic [1:0] rsrc);
    return mk(4'd0, 1, 1, 0, 1, 2'b10, 2'b10, 2'b00, imm, rsrc, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [22:0] decode_v(input logic [1:0] imm,
                                           input logic [1:0] rsrc);
    return mk(4'd1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, imm, rsrc, 2'b00, 0, 0, 0);
  endfunction

  initial begin
    reset = 1'b1;
    set_instr(2'b00, 6'b000000, 4'd0);
    @(posedge clk); #1;
    cyc("reset_state", fetch_v(2'b00, 2'b00));
    reset = 1'b0;

    // LDR R3: Op=01 Funct=011001 -> ImmSrc 01, RegSrc 10
    set_instr(2'b01, 6'b011001, 4'd3);
    cyc("ldr_fetch",  fetch_v(2'b01, 2'b10));
    cyc("ldr_decode", decode_v(2'b01, 2'b10));
    cyc("ldr_memadr", mk(4'd2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    cyc("ldr_memrd",  mk(4'd3, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    cyc("ldr_memwb",  mk(4'd4, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0, 1, 0));

    // LDR R15: PCS asserted in MEMWB
    set_instr(2'b01, 6'b011001, 4'd15);
    cyc("ldrpc_fetch",  fetch_v(2'b01, 2'b10));
    cyc("ldrpc_decode", decode_v(2'b01, 2'b10));
    cyc("ldrpc_memadr", mk(4'd2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    cyc("ldrpc_memrd",  mk(4'd3, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    cyc("ldrpc_memwb",  mk(4'd4, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 1, 1, 0));

    // STR: Op=01 Funct=011000
    set_instr(2'b01, 6'b011000, 4'd15);
    cyc("str_fetch",  fetch_v(2'b01, 2'b10));
    cyc("str_decode", decode_v(2'b01, 2'b10));
    cyc("str_memadr", mk(4'd2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    cyc("str_memwr",  mk(4'd5, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1));

    // ADDS R2, register: Op=00 Funct=001001
    set_instr(2'b00, 6'b001001, 4'd2);
    cyc("adds_fetch",  fetch_v(2'b00, 2'b00));
    cyc("adds_decode", decode_v(2'b00, 2'b00));
    cyc("adds_execr",  mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0));
    cyc("adds_aluwb",  mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));

    // CMP immediate: Op=00 Funct=110101 -> SUB, flags 11, no register write
    set_instr(2'b00, 6'b110101, 4'd0);
    cyc("cmp_fetch",  fetch_v(2'b00, 2'b00));
    cyc("cmp_decode", decode_v(2'b00, 2'b00));
    cyc("cmp_execi",  mk(4'd7, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 0));
    cyc("cmp_aluwb",  mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));

    // ORRS R4: Funct=011001 -> ORR, FlagW 10; NoWrite from CMP must not linger
    set_instr(2'b00, 6'b011001, 4'd4);
    cyc("orrs_fetch",  fetch_v(2'b00, 2'b00));
    cyc("orrs_decode", decode_v(2'b00, 2'b00));
    cyc("orrs_execr",  mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 0, 0, 0));
    cyc("orrs_aluwb",  mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));

    // SUB R15 immediate, no S: Funct=100100 -> SUB, no flags, PCS in ALUWB
    set_instr(2'b00, 6'b100100, 4'd15);
    cyc("subpc_fetch",  fetch_v(2'b00, 2'b00));
    cyc("subpc_decode", decode_v(2'b00, 2'b00));
    cyc("subpc_execi",  mk(4'd7, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    cyc("subpc_aluwb",  mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0));

    // Unsupported opcode 0001 with S=1 (Funct=000011): ADD code, no flags
    set_instr(2'b00, 6'b000011, 4'd1);
    cyc("eor_fetch",  fetch_v(2'b00, 2'b00));
    cyc("eor_decode", decode_v(2'b00, 2'b00));
    cyc("eor_execr",  mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    cyc("eor_aluwb",  mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0));

    // B: Op=10 -> ImmSrc 10, RegSrc 01
    set_instr(2'b10, 6'b100000, 4'd0);
    cyc("b_fetch",  fetch_v(2'b10, 2'b01));
    cyc("b_decode", decode_v(2'b10, 2'b01));
    cyc("b_branch", mk(4'd9, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 1, 0, 0));

    // Undefined: Op=11
    set_instr(2'b11, 6'b000000, 4'd15);
    cyc("undef_fetch",   fetch_v(2'b11, 2'b00));
    cyc("undef_decode",  decode_v(2'b11, 2'b00));
    cyc("undef_unknown", mk(4'd10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0));

    // Reset asserted mid-MEMRD of an LDR
    set_instr(2'b01, 6'b011001, 4'd3);
    cyc("rst_ldr_fetch",  fetch_v(2'b01, 2'b10));
    cyc("rst_ldr_decode", decode_v(2'b01, 2'b10));
    cyc("rst_ldr_memadr", mk(4'd2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    reset = 1'b1;
    #1;
    cyc("rst_in_memrd", fetch_v(2'b01, 2'b10));
    reset = 1'b0;
    cyc("rst_released", fetch_v(2'b01, 2'b10));
    cyc("rst_after_decode", decode_v(2'b01, 2'b10));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
